// File: rtl/tpu_result_reader.sv
// tpu_result_reader: drains rows of the tpu_core result buffer into a valid/ready stream.
module tpu_result_reader #(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [ADDR_WIDTH-1:0]              req_base_addr,
    input  logic [7:0]                         req_rows,
    output logic [ADDR_WIDTH-1:0]              axim_rd_addr_out,
    output logic                               axim_rd_en_out,
    input  logic signed [DATA_WIDTH_ACCUM-1:0] axim_rd_data_in [SYSTOLIC_ARRAY_WIDTH],
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [DATA_WIDTH_ACCUM-1:0] out_data [SYSTOLIC_ARRAY_WIDTH],
    output logic [7:0]                         out_row_idx,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t                             r_state;
    logic [ADDR_WIDTH-1:0]              r_base;
    logic [ADDR_WIDTH-1:0]              r_addr;
    logic [7:0]                         r_rows;
    logic [7:0]                         r_issued;
    logic [7:0]                         r_emitted;
    logic                               r_en;
    logic                               r_pend;
    logic                               r_busy;
    logic                               r_done;
    logic [1:0]                         r_wr;
    logic [1:0]                         r_rd;
    logic [1:0]                         r_count;
    logic signed [DATA_WIDTH_ACCUM-1:0] r_buf [3][SYSTOLIC_ARRAY_WIDTH];
    logic                               w_pop;
    logic                               w_issue;
    logic                               w_fin;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read lands two edges after issue, so slots cover buffered rows plus both pipeline stages.
    always_comb begin
        w_pop   = out_valid && out_ready;
        w_issue = (r_state == S_RUN) && (r_issued != r_rows) &&
                  ({1'b0, r_count} + {2'b0, r_en} + {2'b0, r_pend} <= 3'd2 + {2'b0, w_pop});
        w_fin   = (r_emitted + {7'b0, w_pop}) == r_rows;
    end

    assign req_ready        = r_state == S_IDLE;
    assign axim_rd_addr_out = r_addr;
    assign axim_rd_en_out   = r_en;
    assign out_valid        = r_count != 2'd0;
    assign out_data         = r_buf[r_rd];
    assign out_row_idx      = r_emitted;
    assign out_last         = out_valid && (r_emitted == r_rows - 8'd1);
    assign busy             = r_busy;
    assign done             = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_addr    <= '0;
            r_rows    <= '0;
            r_issued  <= '0;
            r_emitted <= '0;
            r_en      <= 1'b0;
            r_pend    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < SYSTOLIC_ARRAY_WIDTH; j++)
                    r_buf[i][j] <= '0;
        end else begin
            r_pend  <= r_en;
            r_done  <= 1'b0;
            r_en    <= w_issue;
            r_count <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
            if (r_pend) begin
                r_buf[r_wr] <= axim_rd_data_in;
                r_wr        <= nxt(r_wr);
            end
            if (w_pop) begin
                r_rd      <= nxt(r_rd);
                r_emitted <= r_emitted + 8'd1;
            end
            if (w_issue) begin
                r_addr   <= r_base + ADDR_WIDTH'(r_issued);
                r_issued <= r_issued + 8'd1;
            end
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_base    <= req_base_addr;
                    r_rows    <= req_rows;
                    r_emitted <= '0;
                    if (req_rows == 8'd0) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_issued <= '0;
                    end else begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_en     <= 1'b1;
                        r_addr   <= req_base_addr;
                        r_issued <= 8'd1;
                    end
                end
                S_RUN: if (r_issued == r_rows) r_state <= S_DRAIN;
                S_DRAIN: if (w_fin) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_result_reader.sv
// tb_tpu_result_reader: random-data drain runs against a registered-read core model and a row-list reference.
module tb_tpu_result_reader;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [9:0]         req_base_addr = '0;
    logic [7:0]         req_rows = '0;
    logic [9:0]         axim_rd_addr_out;
    logic               axim_rd_en_out;
    logic signed [31:0] rd_data [16];
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [31:0] out_data [16];
    logic [7:0]         out_row_idx;
    logic               out_last;
    logic               busy;
    logic               done;

    tpu_result_reader dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_base_addr(req_base_addr), .req_rows(req_rows),
        .axim_rd_addr_out(axim_rd_addr_out), .axim_rd_en_out(axim_rd_en_out),
        .axim_rd_data_in(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row_idx(out_row_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [511:0] mem [1024];
    int           cyc = 0;
    bit           rnd_mode = 1'b0;
    int           n_run = 0;
    int           n_fail = 0;
    logic [9:0]   rd_q [$];
    int           rd_c [$];
    logic [511:0] hs_d [$];
    int           hs_i [$];
    int           hs_l [$];
    int           hs_c [$];
    int           done_c [$];
    int           n_iss, n_pop, max_occ, busy_n, vld_n, stall_bad;
    bit           stalled;
    logic [511:0] st_d;
    int           st_i, st_l;

    function automatic logic [511:0] pack(input logic signed [31:0] r [16]);
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = r[i];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_q.delete(); rd_c.delete(); hs_d.delete(); hs_i.delete();
        hs_l.delete(); hs_c.delete(); done_c.delete();
        n_iss = 0; n_pop = 0; max_occ = 0; busy_n = 0; vld_n = 0; stall_bad = 0; stalled = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core model: registered read, data present only in the cycle after the sampling edge.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 16; i++)
            rd_data[i] <= axim_rd_en_out ? signed'(mem[axim_rd_addr_out][i*32 +: 32]) : signed'($urandom);
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (axim_rd_en_out) begin
                rd_q.push_back(axim_rd_addr_out);
                rd_c.push_back(cyc);
                n_iss++;
            end
            if (out_valid && out_ready) begin
                hs_d.push_back(pack(out_data));
                hs_i.push_back(int'(out_row_idx));
                hs_l.push_back(int'(out_last));
                hs_c.push_back(cyc);
                n_pop++;
            end
            if (done) done_c.push_back(cyc);
            if (busy) busy_n++;
            if (out_valid) vld_n++;
            if (stalled && !(out_valid && pack(out_data) == st_d &&
                             int'(out_row_idx) == st_i && int'(out_last) == st_l)) stall_bad++;
            stalled = out_valid && !out_ready;
            st_d = pack(out_data);
            st_i = int'(out_row_idx);
            st_l = int'(out_last);
            if (n_iss - n_pop > max_occ) max_occ = n_iss - n_pop;
        end
    end

    task automatic run(input logic [9:0] base, input int rows, input bit rnd, input bit timed, input bit poke);
        int e, g, ea;
        rnd_mode = rnd;
        clear_log();
        req_valid = 1'b1;
        req_base_addr = base;
        req_rows = 8'(rows);
        tick();
        e = cyc;
        req_valid = 1'b0;
        if (poke) begin
            tick();
            req_valid = 1'b1;
            req_base_addr = base + 10'd100;
            req_rows = 8'd7;
            chki("req_ready_in_run", int'(req_ready), 0);
            tick();
            req_valid = 1'b0;
        end
        g = 0;
        while (done_c.size() == 0 && g < 2000) begin
            tick();
            g++;
        end
        tick();
        tick();
        rnd_mode = 1'b0;
        chki("done_count", done_c.size(), 1);
        chki("rd_count", rd_q.size(), rows);
        chki("row_count", hs_d.size(), rows);
        chki("stall_stable", stall_bad, 0);
        chki("occupancy_le_3", int'(max_occ <= 3), 1);
        for (int k = 0; k < rows && k < rd_q.size(); k++)
            chki("rd_addr", int'(rd_q[k]), (int'(base) + k) % 1024);
        for (int k = 0; k < rows && k < hs_d.size(); k++) begin
            ea = (int'(base) + k) % 1024;
            chk("row_data", hs_d[k], mem[ea]);
            chki("row_idx", hs_i[k], k);
            chki("row_last", hs_l[k], int'(k == rows - 1));
        end
        if (timed) begin
            for (int k = 0; k < rows && k < rd_c.size(); k++) chki("rd_cycle", rd_c[k], e + k);
            for (int k = 0; k < rows && k < hs_c.size(); k++) chki("out_cycle", hs_c[k], e + 2 + k);
            if (done_c.size() > 0) chki("done_cycle", done_c[0], rows == 0 ? e : e + rows + 2);
            chki("busy_cycles", busy_n, rows == 0 ? 0 : rows + 2);
            chki("valid_cycles", vld_n, rows);
        end
    endtask

    initial begin
        logic [511:0] lanes;
        int g;
        void'($urandom(32'h5EED_1234));
        for (int a = 0; a < 1024; a++)
            for (int i = 0; i < 16; i++) mem[a][i*32 +: 32] = $urandom;
        for (int i = 0; i < 16; i++) mem[10'h200][i*32 +: 32] = i;
        for (int i = 0; i < 16; i++) lanes[i*32 +: 32] = i;
        for (int i = 0; i < 16; i++) rd_data[i] = '0;
        clear_log();
        repeat (3) tick();
        chki("rst_req_ready", int'(req_ready), 1);
        chki("rst_rd_en", int'(axim_rd_en_out), 0);
        chki("rst_rd_addr", int'(axim_rd_addr_out), 0);
        chki("rst_out_valid", int'(out_valid), 0);
        chki("rst_busy_done", int'({busy, done, out_last}), 0);
        rst = 1'b0;
        tick();

        run(10'h200, 1, 1'b0, 1'b1, 1'b0);
        if (hs_d.size() > 0) chk("row0_lanes_0_15", hs_d[0], lanes);
        run(10'h200, 16, 1'b0, 1'b1, 1'b0);
        run(10'h200, 16, 1'b1, 1'b0, 1'b1);
        run(10'h200, 0, 1'b0, 1'b1, 1'b0);
        run(10'h3FE, 4, 1'b0, 1'b1, 1'b0);
        run(10'($urandom_range(0, 1023)), int'($urandom_range(1, 40)), 1'b1, 1'b0, 1'b1);

        clear_log();
        req_valid = 1'b1;
        req_base_addr = 10'h100;
        req_rows = 8'd16;
        tick();
        req_valid = 1'b0;
        g = 0;
        while (hs_d.size() < 5 && g < 200) begin
            tick();
            g++;
        end
        rst = 1'b1;
        tick();
        chki("mid_rst_req_ready", int'(req_ready), 1);
        chki("mid_rst_rd_en", int'(axim_rd_en_out), 0);
        chki("mid_rst_rd_addr", int'(axim_rd_addr_out), 0);
        chki("mid_rst_valid", int'(out_valid), 0);
        chki("mid_rst_flags", int'({busy, done, out_last}), 0);
        chki("mid_rst_idx", int'(out_row_idx), 0);
        chk("mid_rst_data", pack(out_data), '0);
        rst = 1'b0;
        clear_log();
        repeat (6) tick();
        chki("abort_no_done", done_c.size(), 0);
        chki("abort_no_reads", rd_q.size(), 0);
        chki("abort_no_rows", hs_d.size(), 0);
        run(10'h300, 3, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
